// File: rtl/snake_game_ctrl.sv
// Snake game-state controller: segment store, move sequencing, eat/grow/collide, apple placement
// and per-pixel object classification. Define SNAKE_WRAP_EN for a wrap-around field with no walls.
module snake_game_ctrl #(
   parameter int MAX_LEN    = 16,
   parameter int INIT_LEN   = 3,
   parameter int STEP_TICKS = 12_500_000
) (
   input  logic       Clk_25mhz,
   input  logic       Rst,
   input  logic       Start,
   input  logic       Key_up,
   input  logic       Key_down,
   input  logic       Key_left,
   input  logic       Key_right,
   input  logic [9:0] Pixel_x,
   input  logic [9:0] Pixel_y,
   output logic [1:0] Object,
   output logic [5:0] Apple_x,
   output logic [4:0] Apple_y,
   output logic [1:0] Game_state,
   output logic [7:0] Score
);

   // state | meaning
   // IDLE  | snake shown at start position, waiting for Start
   // PLAY  | tick counter running, one move per STEP_TICKS clocks
   // RELOC | apple eaten, drawing LFSR candidates until one lands on a free cell
   // OVER  | collision, positions frozen, waiting for Start
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_RELOC = 2'b10, S_OVER = 2'b11} state_t;
   typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_t;

   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int TICK_W = $clog2(STEP_TICKS);

   state_t              state;
   dir_t                dir;
   dir_t                pend_dir;
   logic [5:0]          seg_x [MAX_LEN];
   logic [4:0]          seg_y [MAX_LEN];
   logic [LEN_W-1:0]    len;
   logic [TICK_W-1:0]   tick;
   logic [15:0]         lfsr;

   logic                step;
   logic [5:0]          nxt_x;
   logic [4:0]          nxt_y;
   logic                nxt_wall;
   logic                eat;
   logic                self_hit;
   logic                collide;
   logic [5:0]          cand_x;
   logic [4:0]          cand_y;
   logic                cand_range;
   logic                cand_on_snake;
   logic                cand_ok;
   logic [5:0]          pix_cx;
   logic [4:0]          pix_cy;
   logic                pix_in_area;
   logic                pix_head;
   logic                pix_body;
   logic                pix_wall;
   logic [1:0]          obj_nxt;
   logic                key_any;
   dir_t                key_dir;
   dir_t                ref_dir;
   logic                key_ok;

   function automatic logic [5:0] init_x(input int i);
      return (i < INIT_LEN) ? 6'(20 - i) : 6'd0;
   endfunction

   assign Game_state = state;
   assign step       = (state == S_PLAY) && (tick == TICK_W'(STEP_TICKS - 1));

   // The move uses the pending direction: the last accepted key before the step.
   always_comb begin
      nxt_x = seg_x[0];
      nxt_y = seg_y[0];
      unique case (pend_dir)
         D_UP:    nxt_y = (seg_y[0] == 5'd0)  ? 5'd29 : seg_y[0] - 5'd1;
         D_DOWN:  nxt_y = (seg_y[0] == 5'd29) ? 5'd0  : seg_y[0] + 5'd1;
         D_LEFT:  nxt_x = (seg_x[0] == 6'd0)  ? 6'd39 : seg_x[0] - 6'd1;
         D_RIGHT: nxt_x = (seg_x[0] == 6'd39) ? 6'd0  : seg_x[0] + 6'd1;
      endcase
   end

   assign cand_x      = lfsr[5:0];
   assign cand_y      = lfsr[10:6];
   assign pix_cx      = Pixel_x[9:4];
   assign pix_cy      = Pixel_y[8:4];
   assign pix_in_area = (Pixel_x < 10'd640) && (Pixel_y < 10'd480);
   assign pix_head    = (seg_x[0] == pix_cx) && (seg_y[0] == pix_cy);

`ifdef SNAKE_WRAP_EN
   assign nxt_wall   = 1'b0;
   assign pix_wall   = 1'b0;
   assign cand_range = (cand_x <= 6'd39) && (cand_y <= 5'd29);
`else
   assign nxt_wall   = (nxt_x == 6'd0) || (nxt_x == 6'd39) || (nxt_y == 5'd0) || (nxt_y == 5'd29);
   assign pix_wall   = (pix_cx == 6'd0) || (pix_cx == 6'd39) || (pix_cy == 5'd0) || (pix_cy == 5'd29);
   assign cand_range = (cand_x >= 6'd1) && (cand_x <= 6'd38) && (cand_y >= 5'd1) && (cand_y <= 5'd28);
`endif

   assign eat = (nxt_x == Apple_x) && (nxt_y == Apple_y);

   // The tail vacates its cell on a non-eating move, so it cannot be hit then.
   always_comb begin
      self_hit      = 1'b0;
      cand_on_snake = 1'b0;
      pix_body      = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LEN_W'(i) < len) begin
            if ((i != 0) && (seg_x[i] == nxt_x) && (seg_y[i] == nxt_y) &&
                (eat || (LEN_W'(i + 1) != len)))
               self_hit = 1'b1;
            if ((seg_x[i] == cand_x) && (seg_y[i] == cand_y))
               cand_on_snake = 1'b1;
            if ((i != 0) && (seg_x[i] == pix_cx) && (seg_y[i] == pix_cy))
               pix_body = 1'b1;
         end
      end
   end

   assign collide = nxt_wall || self_hit;
   assign cand_ok = cand_range && !cand_on_snake;

   always_comb begin
      obj_nxt = 2'b00;
      if (pix_in_area) begin
         if (pix_head)      obj_nxt = 2'b01;
         else if (pix_body) obj_nxt = 2'b10;
         else if (pix_wall) obj_nxt = 2'b11;
      end
   end

   // On the step cycle the reversal test is against the direction about to take effect.
   assign key_any = Key_up || Key_down || Key_left || Key_right;
   assign key_dir = Key_up ? D_UP : Key_down ? D_DOWN : Key_left ? D_LEFT : D_RIGHT;
   assign ref_dir = step ? pend_dir : dir;
   assign key_ok  = key_any && ({key_dir[1], ~key_dir[0]} != ref_dir);

   always_ff @(posedge Clk_25mhz) begin
      if (Rst) begin
         state    <= S_IDLE;
         dir      <= D_RIGHT;
         pend_dir <= D_RIGHT;
         len      <= LEN_W'(INIT_LEN);
         tick     <= '0;
         lfsr     <= 16'hACE1;
         Apple_x  <= 6'd30;
         Apple_y  <= 5'd10;
         Score    <= 8'd0;
         Object   <= 2'b00;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= 5'd15;
         end
      end else begin
         lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         Object <= obj_nxt;
         unique case (state)
            S_IDLE: begin
               if (Start) begin
                  state <= S_PLAY;
                  tick  <= '0;
               end
            end
            S_PLAY: begin
               if (key_ok)
                  pend_dir <= key_dir;
               if (step) begin
                  tick <= '0;
                  dir  <= pend_dir;
                  if (collide) begin
                     state <= S_OVER;
                  end else begin
                     for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                     end
                     seg_x[0] <= nxt_x;
                     seg_y[0] <= nxt_y;
                     if (eat) begin
                        if (len < LEN_W'(MAX_LEN))
                           len <= len + LEN_W'(1);
                        if (Score != 8'hFF)
                           Score <= Score + 8'd1;
                        state <= S_RELOC;
                     end
                  end
               end else begin
                  tick <= tick + TICK_W'(1);
               end
            end
            S_RELOC: begin
               if (cand_ok) begin
                  Apple_x <= cand_x;
                  Apple_y <= cand_y;
                  state   <= S_PLAY;
               end
            end
            S_OVER: begin
               if (Start) begin
                  state    <= S_PLAY;
                  dir      <= D_RIGHT;
                  pend_dir <= D_RIGHT;
                  len      <= LEN_W'(INIT_LEN);
                  tick     <= '0;
                  Score    <= 8'd0;
                  for (int i = 0; i < MAX_LEN; i++) begin
                     seg_x[i] <= init_x(i);
                     seg_y[i] <= 5'd15;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: directed play sequences, expectations queued with a due
// cycle and compared by a separate monitor on the falling edge.
module tb_snake_game_ctrl;

   localparam int STEP = 4;
   localparam int F_OBJ = 0, F_STATE = 1, F_SCORE = 2, F_AX = 3, F_AY = 4, F_AIN = 5;
   localparam int F_OBJ_B = 6, F_STATE_B = 7, F_SCORE_B = 8, F_AX_B = 9;
`ifdef SNAKE_WRAP_EN
   localparam int WALL_OBJ = 0;
`else
   localparam int WALL_OBJ = 3;
`endif

   typedef struct {
      string name;
      int    due;
      int    fld;
      int    exp;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   base = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, ku = 1'b0, kd = 1'b0, kl = 1'b0, kr = 1'b0;
   logic       start_b = 1'b0, ku_b = 1'b0, kd_b = 1'b0, kl_b = 1'b0, kr_b = 1'b0;
   logic [9:0] px = '0, py = '0;
   logic [1:0] object, game_state, object_b, game_state_b;
   logic [5:0] apple_x, apple_x_b;
   logic [4:0] apple_y, apple_y_b;
   logic [7:0] score, score_b;

   snake_game_ctrl #(.MAX_LEN(16), .INIT_LEN(3), .STEP_TICKS(STEP)) dut (
      .Clk_25mhz(clk), .Rst(rst), .Start(start),
      .Key_up(ku), .Key_down(kd), .Key_left(kl), .Key_right(kr),
      .Pixel_x(px), .Pixel_y(py), .Object(object), .Apple_x(apple_x), .Apple_y(apple_y),
      .Game_state(game_state), .Score(score));

   snake_game_ctrl #(.MAX_LEN(16), .INIT_LEN(5), .STEP_TICKS(STEP)) dut_b (
      .Clk_25mhz(clk), .Rst(rst), .Start(start_b),
      .Key_up(ku_b), .Key_down(kd_b), .Key_left(kl_b), .Key_right(kr_b),
      .Pixel_x(px), .Pixel_y(py), .Object(object_b), .Apple_x(apple_x_b), .Apple_y(apple_y_b),
      .Game_state(game_state_b), .Score(score_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      int i;
      int act;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due <= cyc) begin
            act = -1;
            if (sb[i].due == cyc) begin
               case (sb[i].fld)
                  F_OBJ:     act = int'(object);
                  F_STATE:   act = int'(game_state);
                  F_SCORE:   act = int'(score);
                  F_AX:      act = int'(apple_x);
                  F_AY:      act = int'(apple_y);
`ifdef SNAKE_WRAP_EN
                  F_AIN:     act = int'(apple_x <= 6'd39 && apple_y <= 5'd29);
`else
                  F_AIN:     act = int'(apple_x >= 6'd1 && apple_x <= 6'd38 &&
                                        apple_y >= 5'd1 && apple_y <= 5'd28);
`endif
                  F_OBJ_B:   act = int'(object_b);
                  F_STATE_B: act = int'(game_state_b);
                  F_SCORE_B: act = int'(score_b);
                  F_AX_B:    act = int'(apple_x_b);
                  default:   act = -1;
               endcase
            end
            checks++;
            if (act == sb[i].exp) passes++;
            else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string name, input int due, input int fld, input int exp);
      chk_t c;
      c.name = name;
      c.due  = due;
      c.fld  = fld;
      c.exp  = exp;
      sb.push_back(c);
   endtask

   task automatic expect_now(input string name, input int fld, input int exp);
      push(name, cyc, fld, exp);
   endtask

   task automatic probe_px(input string name, input int x, input int y, input int fld, input int exp);
      px = 10'(x);
      py = 10'(y);
      push(name, cyc + 1, fld, exp);
      tick(1);
   endtask

   task automatic probe(input string name, input int cx, input int cy, input int exp);
      probe_px(name, cx * 16 + 8, cy * 16 + 8, F_OBJ, exp);
   endtask

   task automatic probe_b(input string name, input int cx, input int cy, input int exp);
      probe_px(name, cx * 16 + 8, cy * 16 + 8, F_OBJ_B, exp);
   endtask

   // key vector order: {up, down, left, right}
   task automatic press(input logic [3:0] k);
      {ku, kd, kl, kr} = k;
      tick(1);
      {ku, kd, kl, kr} = 4'b0000;
   endtask

   task automatic press_b(input logic [3:0] k);
      {ku_b, kd_b, kl_b, kr_b} = k;
      tick(1);
      {ku_b, kd_b, kl_b, kr_b} = 4'b0000;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      base = cyc;
   endtask

   task automatic do_start_b();
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      base = cyc;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      expect_now({tag, "_state"}, F_STATE, 0);
      expect_now({tag, "_score"}, F_SCORE, 0);
      expect_now({tag, "_apple_x"}, F_AX, 30);
      expect_now({tag, "_apple_y"}, F_AY, 10);
      expect_now({tag, "_object"}, F_OBJ, 0);
   endtask

   task automatic goto_step(input int k);
      int target;
      target = base + STEP * k;
      checks++;
      if (cyc <= target) passes++;
      else $display("FAIL schedule_step%0d: at cycle %0d, required <= %0d", k, cyc, target);
      while (cyc < target) tick(1);
   endtask

   task automatic wait_play();
      int n;
      n = 0;
      while (game_state !== 2'b01 && n < 300) begin
         tick(1);
         n++;
      end
      checks++;
      if (game_state === 2'b01) passes++;
      else $display("FAIL reloc_timeout: state %0d after %0d cycles, required 1", game_state, n);
      base = cyc;
   endtask

   // From a fresh start: head (20,15) right; ends on the step that eats the apple at (30,10).
   task automatic steer(input bit chk);
      press(4'b0010);
      goto_step(1);
      if (chk) begin
         probe_px("head_px_336_240", 336, 240, F_OBJ, 1);
         probe("tail_19_15", 19, 15, 2);
         probe("past_tail_18_15", 18, 15, 0);
      end
      goto_step(2);
      press(4'b1010);
      goto_step(3);
      if (chk) begin
         probe("up_taken_head_22_14", 22, 14, 1);
         probe("not_right_23_15", 23, 15, 0);
      end
      goto_step(7);
      press(4'b0001);
      goto_step(15);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int  ax, ay;
      bit  down_ok;

      // reset and idle display
      rst_pulse();
      reset_checks("reset");
      probe("idle_head_20_15", 20, 15, 1);
      probe("idle_body_18_15", 18, 15, 2);
      probe("idle_none_17_15", 17, 15, 0);
      probe_px("wall_px_0_0", 0, 0, F_OBJ, WALL_OBJ);
      probe_px("wall_px_639_479", 639, 479, F_OBJ, WALL_OBJ);
      probe_px("offscreen_x_700_10", 700, 10, F_OBJ, 0);
      probe_px("offscreen_y_0_480", 0, 480, F_OBJ, 0);

      // play to the apple, relocation, chase own tail
      do_start();
      expect_now("start_play", F_STATE, 1);
      steer(1'b1);
      expect_now("eat_reloc_state", F_STATE, 2);
      expect_now("eat_apple_held_x", F_AX, 30);
      expect_now("eat_score", F_SCORE, 1);
      wait_play();
      expect_now("apple_interior", F_AIN, 1);
      ax = int'(apple_x);
      ay = int'(apple_y);
      down_ok = !(((ax == 30) || (ax == 29)) && (ay == 11));
      press(down_ok ? 4'b0100 : 4'b1000);
      probe("apple_cell_off_snake", ax, ay, 0);
      probe("grown_tail_27_10", 27, 10, 2);
      probe("beyond_tail_26_10", 26, 10, 0);
      goto_step(1);
      press(4'b0010);
      goto_step(2);
      press(down_ok ? 4'b1000 : 4'b0100);
      goto_step(3);
      expect_now("chase_tail_state", F_STATE, 1);
      expect_now("chase_tail_score", F_SCORE, 1);
      probe("chase_head_29_10", 29, 10, 1);
      probe("chase_body_30_10", 30, 10, 2);

      // reset from play, then reset while relocating
      rst_pulse();
      reset_checks("rst_play");
      do_start();
      steer(1'b0);
      expect_now("reloc2_state", F_STATE, 2);
      expect_now("reloc2_score", F_SCORE, 1);
      rst_pulse();
      reset_checks("rst_reloc");

      // run right into the border
      do_start();
      goto_step(18);
      probe("wall_run_head_38", 38, 15, 1);
      goto_step(19);
`ifdef SNAKE_WRAP_EN
      expect_now("wrap_edge_state", F_STATE, 1);
      goto_step(20);
      expect_now("wrap_state", F_STATE, 1);
      probe("wrap_head_0_15", 0, 15, 1);
      probe("wrap_body_39_15", 39, 15, 2);
`else
      expect_now("wall_over_state", F_STATE, 3);
      probe("frozen_head_38", 38, 15, 1);
      probe("frozen_body_37", 37, 15, 2);
      probe("frozen_body_36", 36, 15, 2);
      probe("frozen_none_35", 35, 15, 0);
      press(4'b1000);
      tick(4);
      expect_now("over_holds", F_STATE, 3);
      do_start();
      expect_now("restart_state", F_STATE, 1);
      expect_now("restart_score", F_SCORE, 0);
      probe("restart_head_20_15", 20, 15, 1);
      probe("restart_none_21_15", 21, 15, 0);
      probe("restart_body_18_15", 18, 15, 2);
      goto_step(1);
      probe("restart_step_head_21", 21, 15, 1);
`endif

      // five-segment snake turning into its own body
      do_start_b();
      expect_now("b_play", F_STATE_B, 1);
      press_b(4'b0100);
      goto_step(1);
      press_b(4'b0010);
      goto_step(2);
      expect_now("b_before_loop", F_STATE_B, 1);
      press_b(4'b1000);
      goto_step(3);
      expect_now("b_loop_over", F_STATE_B, 3);
      expect_now("b_score", F_SCORE_B, 0);
      expect_now("b_apple_x", F_AX_B, 30);
      probe_b("b_head_frozen_19_16", 19, 16, 1);
      probe_b("b_body_19_15", 19, 15, 2);

      tick(3);
      while (sb.size() > 0) begin
         checks++;
         $display("FAIL %s: never sampled, expected %0d", sb[0].name, sb[0].exp);
         sb.delete(0);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
